// File: rtl/wisc_pkg.sv
// Shared types, flag indices, saturation constants and carry-lookahead helpers
// for the WISC execute-stage ALU.
package wisc_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_XOR    = 3'b010,
    OP_RED    = 3'b011,
    OP_PADDSB = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RED2 = 2'b01,
    ST_HOLD = 2'b10
  } alu_state_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam logic [15:0] SAT_POS16 = 16'h7FFF;
  localparam logic [15:0] SAT_NEG16 = 16'h8000;

  // Carries c3..c0 of a 4-bit lookahead block, fully expanded from c0.
  function automatic logic [3:0] cla4_carries(input logic [2:0] g, input logic [2:0] p,
                                              input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Block generate of a 4-bit group (carry out assuming zero carry in).
  function automatic logic cla4_gen(input logic [3:0] g, input logic [3:1] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/wisc_alu_exec_if.sv
// ID/EX token input and EX/MEM result output bundle of the WISC execute ALU.
interface wisc_alu_exec_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [2:0]   flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/cla_add16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit blocks under one
// group lookahead unit.
module cla_add16
  import wisc_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [3:0]  grp_g_s;
  logic [3:0]  grp_p_s;
  logic [3:0]  grp_c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign grp_g_s[k] = cla4_gen(g_s[4*k+3:4*k], p_s[4*k+3:4*k+1]);
    assign grp_p_s[k] = &p_s[4*k+3:4*k];
  end

  assign grp_c_s = cla4_carries(grp_g_s[2:0], grp_p_s[2:0], cin);
  assign cout    = cla4_gen(grp_g_s, grp_p_s[3:1]) | ((&grp_p_s) & cin);

  for (genvar k = 0; k < 4; k++) begin : g_sum
    logic [3:0] c_s;
    assign c_s = cla4_carries(g_s[4*k+2:4*k], p_s[4*k+2:4*k], grp_c_s[k]);
    assign sum[4*k+3:4*k] = p_s[4*k+3:4*k] ^ c_s;
  end
endmodule

// File: rtl/sat_add4.sv
// 4-bit signed saturating adder (clamps to 0x7 / 0x8) used per nibble by PADDSB.
module sat_add4
  import wisc_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum
);
  logic [2:0] g_s;
  logic [3:0] p_s;
  logic [3:0] c_s;
  logic [3:0] raw_s;
  logic       ovf_s;

  assign g_s   = a[2:0] & b[2:0];
  assign p_s   = a ^ b;
  assign c_s   = cla4_carries(g_s, p_s[2:0], 1'b0);
  assign raw_s = p_s ^ c_s;
  assign ovf_s = (a[3] == b[3]) && (raw_s[3] != a[3]);

  // Clamp toward the sign of the operands on overflow.
  always_comb begin
    sum = raw_s;
    if (ovf_s) begin
      sum = a[3] ? 4'h8 : 4'h7;
    end else begin
      sum = raw_s;
    end
  end
endmodule

// File: rtl/wisc_alu_exec.sv
// WISC execute-stage ALU: saturating ADD/SUB, XOR, two-cycle RED and optional
// PADDSB (enabled by defining WISC_ALU_PADDSB_EN), with the Z/V/N flag register.
module wisc_alu_exec
  import wisc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  wisc_alu_exec_if.slave bus
);
  alu_state_t   state_r;
  logic [W-1:0] result_r;
  logic [2:0]   flags_r;
  logic         out_valid_r;
  logic [8:0]   hs_r;
  logic [8:0]   ls_r;

  alu_op_t      op_s;
  logic         in_ready_s;
  logic         accept_s;
  logic [W-1:0] add_a_s;
  logic [W-1:0] add_b_s;
  logic         add_cin_s;
  logic [W-1:0] add_sum_s;
  logic         add_cout_s;
  logic [W-1:0] hi_sum_s;
  logic [W-1:0] lo_sum_s;
  logic         hi_cout_s;
  logic         lo_cout_s;
  logic         ovf_s;
  logic [W-1:0] sat_s;
  logic [W-1:0] xor_s;
  logic [W-1:0] red_result_s;
  logic [W-1:0] nxt_result_s;
  logic [2:0]   nxt_flags_s;
  logic         adder_unused_s;

  assign op_s       = alu_op_t'(bus.op);
  assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  // Main adder serves ADD/SUB on accept and the hs+ls combine during RED2.
  always_comb begin
    add_a_s   = bus.a;
    add_b_s   = bus.b;
    add_cin_s = 1'b0;
    if (state_r == ST_RED2) begin
      add_a_s = {{7{hs_r[8]}}, hs_r};
      add_b_s = {{7{ls_r[8]}}, ls_r};
    end else if (op_s == OP_SUB) begin
      add_b_s   = ~bus.b;
      add_cin_s = 1'b1;
    end else begin
      add_b_s   = bus.b;
      add_cin_s = 1'b0;
    end
  end

  cla_add16 u_add (.a(add_a_s), .b(add_b_s), .cin(add_cin_s), .sum(add_sum_s), .cout(add_cout_s));

  cla_add16 u_red_hi (
    .a({{8{bus.a[15]}}, bus.a[15:8]}), .b({{8{bus.b[15]}}, bus.b[15:8]}),
    .cin(1'b0), .sum(hi_sum_s), .cout(hi_cout_s)
  );

  cla_add16 u_red_lo (
    .a({{8{bus.a[7]}}, bus.a[7:0]}), .b({{8{bus.b[7]}}, bus.b[7:0]}),
    .cin(1'b0), .sum(lo_sum_s), .cout(lo_cout_s)
  );

  // Byte sums only need 9 bits and carry-outs are implied by sign overflow.
  assign adder_unused_s = ^{add_cout_s, hi_cout_s, lo_cout_s, hi_sum_s[15:9], lo_sum_s[15:9]};

  assign ovf_s        = (add_a_s[15] == add_b_s[15]) && (add_sum_s[15] != add_a_s[15]);
  assign sat_s        = ovf_s ? (add_a_s[15] ? SAT_NEG16 : SAT_POS16) : add_sum_s;
  assign xor_s        = bus.a ^ bus.b;
  assign red_result_s = {{6{add_sum_s[9]}}, add_sum_s[9:0]};

`ifdef WISC_ALU_PADDSB_EN
  logic [W-1:0] paddsb_s;

  for (genvar k = 0; k < 4; k++) begin : g_nib
    sat_add4 u_sat (.a(bus.a[4*k+3:4*k]), .b(bus.b[4*k+3:4*k]), .sum(paddsb_s[4*k+3:4*k]));
  end
`endif

  // Result and flag values for every single-cycle opcode.
  always_comb begin
    nxt_result_s = 16'h0000;
    nxt_flags_s  = flags_r;
    case (op_s)
      OP_ADD, OP_SUB: begin
        nxt_result_s        = sat_s;
        nxt_flags_s[FLAG_Z] = (sat_s == 16'h0000);
        nxt_flags_s[FLAG_V] = ovf_s;
        nxt_flags_s[FLAG_N] = sat_s[15];
      end
      OP_XOR: begin
        nxt_result_s        = xor_s;
        nxt_flags_s[FLAG_Z] = (xor_s == 16'h0000);
      end
`ifdef WISC_ALU_PADDSB_EN
      OP_PADDSB: nxt_result_s = paddsb_s;
`endif
      default: nxt_result_s = 16'h0000;
    endcase
  end

  // Control FSM with registered result, flags and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      result_r    <= 16'h0000;
      flags_r     <= 3'b000;
      out_valid_r <= 1'b0;
      hs_r        <= 9'h000;
      ls_r        <= 9'h000;
    end else begin
      case (state_r)
        ST_IDLE, ST_HOLD: begin
          if (accept_s) begin
            if (op_s == OP_RED) begin
              hs_r        <= hi_sum_s[8:0];
              ls_r        <= lo_sum_s[8:0];
              out_valid_r <= 1'b0;
              state_r     <= ST_RED2;
            end else begin
              result_r    <= nxt_result_s;
              flags_r     <= nxt_flags_s;
              out_valid_r <= 1'b1;
              state_r     <= ST_HOLD;
            end
          end else if ((state_r == ST_HOLD) && bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        ST_RED2: begin
          result_r    <= red_result_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_HOLD;
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;
endmodule

// File: tb/tb_wisc_alu_exec.sv
// Scoreboard bench for wisc_alu_exec; PADDSB expectations follow WISC_ALU_PADDSB_EN.
module tb_wisc_alu_exec;
  import wisc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wisc_alu_exec_if #(.W(16)) bus_if ();
  wisc_alu_exec #(.W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  int n_vec  = 0;
  int n_fail = 0;
  logic [18:0] sb[$];

`ifdef WISC_ALU_PADDSB_EN
  localparam logic [15:0] EXP_P1 = 16'h7777;
  localparam logic [15:0] EXP_P2 = 16'h8888;
`else
  localparam logic [15:0] EXP_P1 = 16'h0000;
  localparam logic [15:0] EXP_P2 = 16'h0000;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on the result side pops one expectation.
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL mon_unexpected: got result 0x%h with no pending token", bus_if.result);
        end else begin
          e = sb.pop_front();
          check("mon_result", bus_if.result, e[18:3]);
          check("mon_flags", {13'd0, bus_if.flags}, {13'd0, e[2:0]});
        end
      end
    end
  end

  task automatic send(input logic [2:0] op_v, input logic [15:0] a_v, input logic [15:0] b_v,
                      input logic [15:0] exp_r, input logic [2:0] exp_f, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    bus_if.in_valid = 1'b1;
    bus_if.op       = op_v;
    bus_if.a        = a_v;
    bus_if.b        = b_v;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (ok) begin
      sb.push_back({exp_r, exp_f});
      @(posedge clk);
      #1;
    end else begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: op %b not accepted after %0d cycles, required acceptance", op_v, waited);
    end
    bus_if.in_valid = 1'b0;
  endtask

  initial begin
    int w;
    bus_if.in_valid  = 1'b0;
    bus_if.op        = 3'b000;
    bus_if.a         = 16'h0000;
    bus_if.b         = 16'h0000;
    bus_if.out_ready = 1'b1;
    rst_n            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {15'd0, bus_if.out_valid}, 16'd0);
    check("rst_result", bus_if.result, 16'h0000);
    check("rst_flags", {13'd0, bus_if.flags}, 16'd0);
    check("rst_in_ready", {15'd0, bus_if.in_ready}, 16'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(3'b000, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010, w);
    check("add_lat_valid", {15'd0, bus_if.out_valid}, 16'd1);
    check("add_sat_result", bus_if.result, 16'h7FFF);
    check("add_sat_flags", {13'd0, bus_if.flags}, 16'd2);
    send(3'b001, 16'h8000, 16'h0001, 16'h8000, 3'b011, w);
    send(3'b010, 16'h5A5A, 16'h5A5A, 16'h0000, 3'b111, w);
    check("xor_flags", {13'd0, bus_if.flags}, 16'd7);

    send(3'b011, 16'h7F7F, 16'h7F7F, 16'h01FC, 3'b111, w);
    check("red_in_ready_low", {15'd0, bus_if.in_ready}, 16'd0);
    check("red_valid_low", {15'd0, bus_if.out_valid}, 16'd0);
    @(posedge clk);
    #1;
    check("red_lat_valid", {15'd0, bus_if.out_valid}, 16'd1);
    check("red_result", bus_if.result, 16'h01FC);

    send(3'b111, 16'h7777, 16'h1111, EXP_P1, 3'b111, w);
    send(3'b111, 16'h8888, 16'hFFFF, EXP_P2, 3'b111, w);
    send(3'b100, 16'h1234, 16'h5678, 16'h0000, 3'b111, w);

    // Backpressure: result must hold and the input side must stall.
    send(3'b000, 16'h0003, 16'h0004, 16'h0007, 3'b000, w);
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_result", bus_if.result, 16'h0007);
      check("bp_valid", {15'd0, bus_if.out_valid}, 16'd1);
      check("bp_in_ready", {15'd0, bus_if.in_ready}, 16'd0);
      check("bp_flags", {13'd0, bus_if.flags}, 16'd0);
    end
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b1;
    send(3'b001, 16'h0005, 16'h0007, 16'hFFFE, 3'b001, w);
    check("b2b_wait0", 16'(w), 16'd0);
    check("b2b_result0", bus_if.result, 16'hFFFE);
    send(3'b000, 16'h4000, 16'h4000, 16'h7FFF, 3'b010, w);
    check("b2b_wait1", 16'(w), 16'd0);
    check("b2b_result1", bus_if.result, 16'h7FFF);
    send(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 3'b100, w);
    send(3'b001, 16'h0001, 16'h8000, 16'h7FFF, 3'b010, w);
    send(3'b011, 16'h80FF, 16'h0101, 16'hFF81, 3'b010, w);
    @(posedge clk);
    #1;
    check("red_neg_result", bus_if.result, 16'hFF81);

    // Asynchronous reset while a reduction is in flight.
    send(3'b011, 16'h8080, 16'h8080, 16'hFE00, 3'b010, w);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {15'd0, bus_if.out_valid}, 16'd0);
    check("arst_result", bus_if.result, 16'h0000);
    check("arst_flags", {13'd0, bus_if.flags}, 16'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {15'd0, bus_if.in_ready}, 16'd1);
    send(3'b011, 16'h8080, 16'h8080, 16'hFE00, 3'b000, w);
    check("post_rst_red_pending", {15'd0, bus_if.out_valid}, 16'd0);
    @(posedge clk);
    #1;
    check("post_rst_red_valid", {15'd0, bus_if.out_valid}, 16'd1);
    check("post_rst_red_result", bus_if.result, 16'hFE00);
    send(3'b010, 16'h00FF, 16'h0F0F, 16'h0FF0, 3'b000, w);

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
